// File: rtl/dispense_request_ctrl.sv
// Purchase front end: synchronises and debounces the customer button, then issues one
// inventory reduce pulse per accepted sale, runs the motor and flashes the sold-out LED.
module dispense_request_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DISPENSE_CYCLES = 8,
   parameter int DENY_CYCLES     = 4,
   parameter int CNT_W           = 4
) (
   input  logic       clk1,
   input  logic       reset1,
   input  logic       btnRaw,
   input  logic       stockAvail,
   output logic       redInventario,
   output logic       motorOn,
   output logic       denyLed,
   output logic       busy,
   output logic [7:0] saleCount
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      DISPENSE     = 2'd1,
      DENY         = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISPENSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DENY_LAST = CNT_W'(DENY_CYCLES - 1);

   logic             s1, s2;
   logic             btn_stable, btn_prev;
   logic [CNT_W-1:0] db_cnt;
   logic             press;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] timer, timer_nxt;
   logic             accept;
   logic             red_nxt, motor_nxt, deny_nxt, busy_nxt;
   logic [7:0]       sale_nxt;

   // The counter tracks consecutive edges where the synchronised button disagrees
   // with the stable level; any agreeing edge restarts it.
   always_ff @(posedge clk1) begin
      if (reset1) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         btn_stable <= 1'b0;
         btn_prev   <= 1'b0;
         db_cnt     <= '0;
      end else begin
         s1       <= btnRaw;
         s2       <= s1;
         btn_prev <= btn_stable;
         if (s2 == btn_stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            btn_stable <= s2;
            db_cnt     <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   assign press = btn_stable & ~btn_prev;

   always_ff @(posedge clk1) begin
      if (reset1) begin
         state         <= IDLE;
         timer         <= '0;
         redInventario <= 1'b0;
         motorOn       <= 1'b0;
         denyLed       <= 1'b0;
         busy          <= 1'b0;
         saleCount     <= 8'd0;
      end else begin
         state         <= state_nxt;
         timer         <= timer_nxt;
         redInventario <= red_nxt;
         motorOn       <= motor_nxt;
         denyLed       <= deny_nxt;
         busy          <= busy_nxt;
         saleCount     <= sale_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      case (state)
         IDLE: begin
            if (press) begin
               if (stockAvail) begin
                  state_nxt = DISPENSE;
                  timer_nxt = DISP_LAST;
               end else begin
                  state_nxt = DENY;
                  timer_nxt = DENY_LAST;
               end
            end
         end
         DISPENSE, DENY: begin
            if (timer == '0) state_nxt = WAIT_RELEASE;
            else             timer_nxt = timer - 1'b1;
         end
         WAIT_RELEASE: begin
            // Holding the button parks here, so a held press never repeats.
            if (!btn_stable) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the upcoming state so they line up with it.
   always_comb begin
      accept    = (state == IDLE) && press && stockAvail;
      red_nxt   = accept;
      motor_nxt = (state_nxt == DISPENSE);
      deny_nxt  = (state_nxt == DENY);
      busy_nxt  = (state_nxt != IDLE);
      sale_nxt  = saleCount + {7'd0, accept};
   end

endmodule

// File: tb/tb_dispense_request_ctrl.sv
// Directed and randomized bench for dispense_request_ctrl against a duration-based
// reference model (sliding-window debounce, remaining-time counters for actions).
module tb_dispense_request_ctrl;

   localparam int DB   = 4;
   localparam int DISP = 8;
   localparam int DNY  = 4;

   logic       clk1 = 1'b0;
   logic       reset1, btnRaw, stockAvail;
   logic       redInventario, motorOn, denyLed, busy;
   logic [7:0] saleCount;

   int checks = 0, passes = 0, fails = 0;
   int red_seen = 0, deny_seen = 0;
   int inv = 0;
   bit inv_track = 0;

   // reference model state
   bit m_s1, m_s2, m_stable, m_prev, m_red, wait_rel;
   bit win[$];
   int motor_left, deny_left, m_sales;

   dispense_request_ctrl #(
      .DEBOUNCE_CYCLES(DB), .DISPENSE_CYCLES(DISP), .DENY_CYCLES(DNY), .CNT_W(4)
   ) dut (
      .clk1(clk1), .reset1(reset1), .btnRaw(btnRaw), .stockAvail(stockAvail),
      .redInventario(redInventario), .motorOn(motorOn), .denyLed(denyLed),
      .busy(busy), .saleCount(saleCount)
   );

   always #5 clk1 = ~clk1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      bit press, s2_pre, stable_pre, all_diff;
      if (reset1) begin
         m_s1 = 0; m_s2 = 0; m_stable = 0; m_prev = 0; m_red = 0; wait_rel = 0;
         win.delete(); motor_left = 0; deny_left = 0; m_sales = 0;
         return;
      end
      press      = m_stable && !m_prev;
      s2_pre     = m_s2;
      stable_pre = m_stable;
      m_s2   = m_s1;
      m_s1   = btnRaw;
      m_prev = stable_pre;
      win.push_back(s2_pre);
      if (win.size() > DB) void'(win.pop_front());
      all_diff = (win.size() == DB);
      foreach (win[k]) if (win[k] == stable_pre) all_diff = 0;
      if (all_diff) begin
         m_stable = s2_pre;
         win.delete();
      end
      m_red = 0;
      if (motor_left > 0) begin
         motor_left--;
         if (motor_left == 0) wait_rel = 1;
      end else if (deny_left > 0) begin
         deny_left--;
         if (deny_left == 0) wait_rel = 1;
      end else if (wait_rel) begin
         if (!stable_pre) wait_rel = 0;
      end else if (press) begin
         if (stockAvail) begin
            m_red = 1;
            motor_left = DISP;
            m_sales = (m_sales + 1) % 256;
         end else begin
            deny_left = DNY;
         end
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk1);
         model_step();
         #1;
         check("red",   redInventario, m_red);
         check("motor", motorOn, motor_left > 0);
         check("deny",  denyLed, deny_left > 0);
         check("busy",  busy, (motor_left > 0) || (deny_left > 0) || wait_rel);
         check("sales", saleCount, m_sales);
         if (redInventario) red_seen++;
         if (denyLed) deny_seen++;
         if (inv_track) begin
            if (redInventario && inv > 0) inv--;
            stockAvail = (inv > 0);
         end
      end
   endtask

   task automatic do_reset();
      reset1 = 1; btnRaw = 0;
      cyc(2);
      reset1 = 0;
      red_seen = 0; deny_seen = 0;
   endtask

   initial begin
      int len;
      reset1 = 1; btnRaw = 0; stockAvail = 1;
      cyc(2);
      check("rst_red", redInventario, 0);
      check("rst_motor", motorOn, 0);
      check("rst_busy", busy, 0);
      check("rst_sales", saleCount, 0);
      reset1 = 0;

      // single held press: pulse after edge 7, motor for 8 cycles
      red_seen = 0;
      btnRaw = 1;
      cyc(6);
      check("t1_no_red_e6", redInventario, 0);
      cyc(1);
      check("t1_red_e7", redInventario, 1);
      check("t1_motor_e7", motorOn, 1);
      cyc(7);
      check("t1_motor_e14", motorOn, 1);
      cyc(1);
      check("t1_motor_off_e15", motorOn, 0);
      check("t1_busy_e15", busy, 1);
      cyc(5);
      btnRaw = 0;
      cyc(20);
      check("t1_pulses", red_seen, 1);
      check("t1_sales", saleCount, 1);
      check("t1_idle", busy, 0);

      // glitch shorter than the debounce window
      do_reset();
      len = 1 + $urandom_range(0, DB - 2);
      btnRaw = 1; cyc(len);
      btnRaw = 0; cyc(12);
      check("t2_pulses", red_seen, 0);
      check("t2_deny", deny_seen, 0);
      check("t2_sales", saleCount, 0);

      // three sales drain inventory, fourth press is refused
      do_reset();
      inv = 3; inv_track = 1; stockAvail = 1;
      repeat (4) begin
         btnRaw = 1; cyc(10 + $urandom_range(0, 5));
         btnRaw = 0; cyc(12);
      end
      inv_track = 0;
      check("t3_pulses", red_seen, 3);
      check("t3_sales", saleCount, 3);
      check("t3_deny_cycles", deny_seen, DNY);

      // long hold never repeats
      do_reset();
      stockAvail = 1;
      btnRaw = 1; cyc(40);
      check("t4_busy_held", busy, 1);
      check("t4_pulses", red_seen, 1);
      btnRaw = 0; cyc(12);
      check("t4_released", busy, 0);

      // reset in the third dispense cycle, button held through it
      do_reset();
      btnRaw = 1; cyc(9);
      check("t5_motor_pre", motorOn, 1);
      reset1 = 1; cyc(1);
      check("t5_motor_rst", motorOn, 0);
      check("t5_busy_rst", busy, 0);
      check("t5_sales_rst", saleCount, 0);
      reset1 = 0; red_seen = 0;
      cyc(15);
      check("t5_repress", red_seen, 1);
      btnRaw = 0; cyc(12);

      // 256 sales with stockAvail toggled during dispense
      do_reset();
      for (int s = 0; s < 256; s++) begin
         stockAvail = 1; btnRaw = 1; cyc(7);
         len = 1 + $urandom_range(0, 7);
         repeat (len) begin
            stockAvail = $urandom_range(0, 1);
            cyc(1);
         end
         btnRaw = 0;
         repeat (12) begin
            stockAvail = $urandom_range(0, 1);
            cyc(1);
         end
         if (s == 254) check("t6_sales_255", saleCount, 255);
      end
      check("t6_pulses", red_seen, 256);
      check("t6_wrap", saleCount, 0);

      // random soak: arbitrary button run lengths and stock flag
      do_reset();
      for (int r = 0; r < 300; r++) begin
         btnRaw = $urandom_range(0, 1);
         stockAvail = $urandom_range(0, 1);
         cyc($urandom_range(1, 10));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
